// File: rtl/rr_push_pkg.sv
// rr_push_pkg: shared constants and helpers for the round-robin push distributor.
//   RR_LANES  - number of destination FIFOs (fixed at 4)
//   RR_ID_W   - width of a lane index
//   RR_CNT_W  - width of the push counter
//   ST_EMPTY / ST_HOLD - holding-register FSM states (state bit == hold_valid)
package rr_push_pkg;

   localparam int RR_LANES = 4;
   localparam int RR_ID_W  = 2;
   localparam int RR_CNT_W = 8;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   // Next lane in rotation; wraps 3 -> 0 through natural 2-bit overflow.
   function automatic logic [RR_ID_W-1:0] lane_inc(input logic [RR_ID_W-1:0] idx);
      return idx + 2'd1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority picker.
//   ptr   in  - highest-priority lane index
//   mask  in  - per-lane eligibility (1 = lane may be chosen, i.e. not full)
//   sel   out - first eligible lane in order ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   found out - at least one lane is eligible
module rr_pick
   import rr_push_pkg::*;
(
   input  logic [RR_ID_W-1:0]  ptr,
   input  logic [RR_LANES-1:0] mask,
   output logic [RR_ID_W-1:0]  sel,
   output logic                found
);

   logic [RR_ID_W-1:0] idx_s;

   // Scan offsets from farthest to nearest so the lane closest to ptr wins last.
   always_comb begin
      sel   = ptr;
      found = 1'b0;
      idx_s = ptr;
      for (int k = RR_LANES - 1; k >= 0; k--) begin
         idx_s = ptr + k[RR_ID_W-1:0];
         if (mask[idx_s]) begin
            sel   = idx_s;
            found = 1'b1;
         end else begin
            sel   = sel;
            found = found;
         end
      end
   end

endmodule

// File: rtl/rr_push.sv
// rr_push: round-robin push distributor feeding four downstream FIFOs.
// A one-entry holding register accepts words from upstream and pushes each
// one to the next non-full lane in rotating order.
//   clk       in  - rising-edge clock
//   reset     in  - asynchronous, active-high reset
//   data_in   in  - incoming word
//   valid_in  in  - data_in valid this cycle
//   ready_out out - block accepts a word this cycle
//   full      in  - per-lane FIFO full flags
//   push      out - one-hot push strobe (or all zero)
//   push_id   out - lane being pushed; equals ptr when idle
//   data_out  out - word being pushed (meaningful only while |push)
//   push_cnt  out - total words pushed, wraps 255 -> 0
module rr_push
   import rr_push_pkg::*;
#(
   parameter int DATA_W = 5,
   parameter int LANES  = 4
)(
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_W-1:0]   data_in,
   input  logic                valid_in,
   output logic                ready_out,
   input  logic [LANES-1:0]    full,
   output logic [LANES-1:0]    push,
   output logic [RR_ID_W-1:0]  push_id,
   output logic [DATA_W-1:0]   data_out,
   output logic [RR_CNT_W-1:0] push_cnt
);

   logic                hold_valid_q, hold_valid_d;
   logic [DATA_W-1:0]   hold_data_q,  hold_data_d;
   logic [RR_ID_W-1:0]  ptr_q,        ptr_d;
   logic [RR_CNT_W-1:0] push_cnt_q,   push_cnt_d;

   logic [RR_ID_W-1:0]  sel_s;
   logic                found_s;
   logic                fire_s;
   logic                accept_s;

   rr_pick u_pick (
      .ptr   (ptr_q),
      .mask  (~full),
      .sel   (sel_s),
      .found (found_s)
   );

   // Push strobe, handshake and output mux; selection follows the current full flags.
   always_comb begin
      fire_s    = hold_valid_q & found_s;
      push      = fire_s ? ({{(LANES-1){1'b0}}, 1'b1} << sel_s) : {LANES{1'b0}};
      push_id   = fire_s ? sel_s : ptr_q;
      data_out  = hold_data_q;
      // Accepting while pushing keeps one word per cycle; reset forces not-ready.
      ready_out = ~reset & (~hold_valid_q | fire_s);
      accept_s  = valid_in & ready_out;
   end

   // Next-state logic for the holding register FSM, rotation pointer and counter.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      ptr_d        = ptr_q;
      push_cnt_d   = push_cnt_q;
      case (hold_valid_q)
         ST_EMPTY: begin
            if (accept_s) begin
               hold_valid_d = 1'b1;
               hold_data_d  = data_in;
            end else begin
               hold_valid_d = 1'b0;
            end
         end
         ST_HOLD: begin
            if (fire_s) begin
               ptr_d      = lane_inc(sel_s);
               push_cnt_d = push_cnt_q + 8'd1;
               if (accept_s) begin
                  hold_valid_d = 1'b1;
                  hold_data_d  = data_in;
               end else begin
                  hold_valid_d = 1'b0;
               end
            end else begin
               // All lanes full: stall with everything frozen.
               hold_valid_d = 1'b1;
            end
         end
         default: begin
            hold_valid_d = 1'b0;
         end
      endcase
   end

   // State registers; reset discards any held word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_valid_q <= 1'b0;
         hold_data_q  <= {DATA_W{1'b0}};
         ptr_q        <= 2'd0;
         push_cnt_q   <= 8'd0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         ptr_q        <= ptr_d;
         push_cnt_q   <= push_cnt_d;
      end
   end

   assign push_cnt = push_cnt_q;

endmodule

// File: tb/tb_rr_push.sv
// tb_rr_push: directed, table-driven bench for rr_push plus hand-written
// sequences for backpressure, mid-operation reset and counter wrap.
module tb_rr_push;

   logic       clk;
   logic       reset;
   logic [4:0] data_in;
   logic       valid_in;
   logic       ready_out;
   logic [3:0] full;
   logic [3:0] push;
   logic [1:0] push_id;
   logic [4:0] data_out;
   logic [7:0] push_cnt;

   int checks;
   int failures;

   rr_push dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .full      (full),
      .push      (push),
      .push_id   (push_id),
      .data_out  (data_out),
      .push_cnt  (push_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       vin;
      logic [4:0] din;
      logic [3:0] full;
      logic [3:0] e_push;
      logic [1:0] e_id;
      logic [4:0] e_dout;
      logic       e_rdy;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference picker: first non-full lane starting at p.
   function automatic int pick(input int p, input logic [3:0] f);
      for (int k = 0; k < 4; k++) begin
         if (!f[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   initial begin
      int m_ptr, m_cnt, m_hv, seq, exp_pop, cyc, s, fire, exp_push;

      checks = 0; failures = 0;
      reset = 1'b1; data_in = 5'h00; valid_in = 1'b0; full = 4'b0000;

      //            vin   din    full     push     id    dout   rdy  cnt
      // steady stream 01..05 with all lanes free
      vecs[0]  = '{1'b1, 5'h01, 4'b0000, 4'b0000, 2'd0, 5'h00, 1'b1, 8'd0};
      vecs[1]  = '{1'b1, 5'h02, 4'b0000, 4'b0001, 2'd0, 5'h01, 1'b1, 8'd0};
      vecs[2]  = '{1'b1, 5'h03, 4'b0000, 4'b0010, 2'd1, 5'h02, 1'b1, 8'd1};
      vecs[3]  = '{1'b1, 5'h04, 4'b0000, 4'b0100, 2'd2, 5'h03, 1'b1, 8'd2};
      vecs[4]  = '{1'b1, 5'h05, 4'b0000, 4'b1000, 2'd3, 5'h04, 1'b1, 8'd3};
      vecs[5]  = '{1'b0, 5'h00, 4'b0000, 4'b0001, 2'd0, 5'h05, 1'b1, 8'd4};
      vecs[6]  = '{1'b0, 5'h00, 4'b0000, 4'b0000, 2'd1, 5'h05, 1'b1, 8'd5};
      // skip full lane 1 with ptr=1
      vecs[7]  = '{1'b1, 5'h1A, 4'b0000, 4'b0000, 2'd1, 5'h05, 1'b1, 8'd5};
      vecs[8]  = '{1'b0, 5'h00, 4'b0010, 4'b0100, 2'd2, 5'h1A, 1'b1, 8'd5};
      vecs[9]  = '{1'b0, 5'h00, 4'b0000, 4'b0000, 2'd3, 5'h1A, 1'b1, 8'd6};
      // hold 0F, all full for 3 cycles, then only lane 2 free
      vecs[10] = '{1'b1, 5'h0F, 4'b0000, 4'b0000, 2'd3, 5'h1A, 1'b1, 8'd6};
      vecs[11] = '{1'b1, 5'h10, 4'b1111, 4'b0000, 2'd3, 5'h0F, 1'b0, 8'd6};
      vecs[12] = '{1'b1, 5'h10, 4'b1111, 4'b0000, 2'd3, 5'h0F, 1'b0, 8'd6};
      vecs[13] = '{1'b1, 5'h10, 4'b1111, 4'b0000, 2'd3, 5'h0F, 1'b0, 8'd6};
      vecs[14] = '{1'b1, 5'h10, 4'b1011, 4'b0100, 2'd2, 5'h0F, 1'b1, 8'd6};
      vecs[15] = '{1'b0, 5'h00, 4'b0000, 4'b1000, 2'd3, 5'h10, 1'b1, 8'd7};
      vecs[16] = '{1'b0, 5'h00, 4'b0000, 4'b0000, 2'd0, 5'h10, 1'b1, 8'd8};

      // Reset state while reset is held
      @(negedge clk);
      chk("rst_push",  push,      0);
      chk("rst_id",    push_id,   0);
      chk("rst_dout",  data_out,  0);
      chk("rst_ready", ready_out, 0);
      chk("rst_cnt",   push_cnt,  0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Table-driven directed vectors
      for (int i = 0; i < 17; i++) begin
         valid_in = vecs[i].vin;
         data_in  = vecs[i].din;
         full     = vecs[i].full;
         @(negedge clk);
         chk($sformatf("v%0d_push", i),  push,      vecs[i].e_push);
         chk($sformatf("v%0d_id", i),    push_id,   vecs[i].e_id);
         chk($sformatf("v%0d_dout", i),  data_out,  vecs[i].e_dout);
         chk($sformatf("v%0d_ready", i), ready_out, vecs[i].e_rdy);
         chk($sformatf("v%0d_cnt", i),   push_cnt,  vecs[i].e_cnt);
         @(posedge clk); #1;
      end

      // Backpressure integrity: words 0..31 under random full patterns
      m_ptr = 0; m_cnt = 8; m_hv = 0; seq = 0; exp_pop = 0; cyc = 0;
      while (exp_pop < 32 && cyc < 2000) begin
         valid_in = (seq < 32);
         data_in  = 5'(seq);
         full     = 4'($urandom_range(0, 15));
         @(negedge clk);
         s        = pick(m_ptr, full);
         fire     = (m_hv != 0) && (s >= 0);
         exp_push = fire ? (1 << s) : 0;
         chk("bp_push",  push,      exp_push);
         chk("bp_id",    push_id,   fire ? s : m_ptr);
         chk("bp_ready", ready_out, ((m_hv == 0) || fire) ? 1 : 0);
         if (fire) begin
            chk("bp_data", data_out, exp_pop);
            exp_pop++;
            m_ptr = (s + 1) % 4;
            m_cnt = (m_cnt + 1) % 256;
         end
         if (valid_in && ((m_hv == 0) || fire)) begin
            seq++;
            m_hv = 1;
         end else if (fire) begin
            m_hv = 0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("bp_all_pushed", exp_pop, 32);
      valid_in = 1'b0; full = 4'b0000;
      @(negedge clk);
      chk("bp_cnt", push_cnt, m_cnt);
      @(posedge clk); #1;

      // Async reset while holding 0x11 with all lanes full
      valid_in = 1'b1; data_in = 5'h11; full = 4'b1111;
      @(posedge clk); #1;
      valid_in = 1'b0;
      @(negedge clk);
      chk("ar_hold_ready", ready_out, 0);
      chk("ar_hold_push",  push,      0);
      chk("ar_hold_dout",  data_out,  5'h11);
      #2 reset = 1'b1;
      #1 full = 4'b0000;
      #1;
      chk("ar_push",  push,      0);
      chk("ar_ready", ready_out, 0);
      chk("ar_id",    push_id,   0);
      chk("ar_cnt",   push_cnt,  0);
      chk("ar_dout",  data_out,  0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("ar_post_push",  push,      0);
         chk("ar_post_ready", ready_out, 1);
         chk("ar_post_id",    push_id,   0);
         chk("ar_post_cnt",   push_cnt,  0);
         @(posedge clk); #1;
      end

      // Counter wrap: 256 pushes with all lanes free
      for (int k = 0; k < 258; k++) begin
         valid_in = (k < 256);
         data_in  = 5'(k);
         full     = 4'b0000;
         @(negedge clk);
         chk("wr_cnt",  push_cnt, (k == 0) ? 0 : ((k - 1) % 256));
         chk("wr_push", push, (k >= 1 && k <= 256) ? (1 << ((k - 1) % 4)) : 0);
         if (k == 257) begin
            chk("wr_final_id",    push_id,   0);
            chk("wr_final_ready", ready_out, 1);
         end
         @(posedge clk); #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_push.md
# rr_push

Round-robin push distributor: the write-side counterpart of the round-robin pop arbiter (`mid`). It accepts a stream of words through a one-entry holding register and pushes each word into one of four downstream FIFOs. Lanes are served in rotating order, and lanes reporting full are skipped. It sits upstream of the four-FIFO bank whose `empty` flags the pop arbiter consumes.

## Interface
Parameters:
- `DATA_W`, default 5: word width (matches one 5-bit slice of the 20-bit `request` bus).
- `LANES`, default 4: number of destination FIFOs. Fixed at 4 in this revision.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `data_in`  in  DATA_W  incoming word.
- `valid_in`  in  1  `data_in` is valid this cycle.
- `ready_out`  out  1  block can accept a word this cycle.
- `full`  in  4  per-lane FIFO full flags, bit i = lane i.
- `push`  out  4  one-hot push strobe to lane i, or all zero.
- `push_id`  out  2  lane index of the current push; equals `ptr` when idle.
- `data_out`  out  DATA_W  word being pushed; valid only when `|push`.
- `push_cnt`  out  8  total words pushed, wraps 255 -> 0.

## Operation
- Internal state:
  - `hold_valid`, `hold_data`: the one-entry holding register.
  - `ptr[1:0]`: the highest-priority lane.
  - `push_cnt`.
- FSM has two states:
  - EMPTY (`hold_valid`=0): accept when `valid_in`, then go to HOLD.
  - HOLD (`hold_valid`=1): attempt a push each cycle.
- Lane selection (combinational):
  - `sel` = first lane i in order `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4) with `full[i]`=0.
  - `found` = any lane not full.
- `fire` = `hold_valid` & `found`.
- Outputs:
  - `push` = `fire ? (1<<sel) : 0`.
  - `push_id` = `fire ? sel : ptr`.
  - `data_out` = `hold_data`.
- `ready_out` = ~`reset` & (~`hold_valid` | `fire`).
  - A new word is accepted in the same cycle the held word is pushed, giving full throughput of 1 word/cycle.
- On `fire`: `ptr` <= `sel`+1 (mod 4) and `push_cnt` <= `push_cnt`+1 (mod 256).
- On accept (`valid_in` & `ready_out`): `hold_data` <= `data_in` and `hold_valid` <= 1.
  - Otherwise, if `fire`, `hold_valid` <= 0.
- All lanes full while in HOLD: no push; `ptr`, `hold_data` and `push_cnt` are unchanged; `ready_out`=0. The stall lasts as long as all lanes stay full.
- `full` changing while in HOLD: takes effect the same cycle, because selection is purely combinational on the current `full`.
- `valid_in` while `ready_out`=0: the word is not taken. The upstream must hold it until the cycle where `ready_out`=1.

## Timing
- Latency: word accepted at edge N, pushed in cycle N+1 (`push` high combinationally from registered `hold_valid`), provided a lane is free.
- Reset (async, immediate) sets:
  - `hold_valid`=0, `hold_data`=0, `ptr`=0, `push_cnt`=0.
  - Resulting outputs: `push`=0000, `push_id`=0, `data_out`=0, `ready_out`=0 while `reset` is high.
  - After deassertion: `ready_out`=1.
- Reset mid-operation: any held word is discarded and no push is issued.
- Wrap-around:
  - `ptr` wraps 3 -> 0.
  - `push_cnt` wraps 255 -> 0.
- Downstream FIFOs sample `push`/`data_out` on the same `clk` edge. `full` must reflect the FIFO state before that edge.

## Structure
- Shared include (`rr_defs.v`) holds `define constants: `LANES`=4, `ID_W`=2, `CNT_W`=8. The pop arbiter uses the same file.
- One sub-module, `rr_pick`: rotating-priority picker, inputs `ptr[1:0]` and `mask[3:0]` (= ~`full`), outputs `sel[1:0]` and `found`.
- Top level: holding register, FSM, `ptr`/`push_cnt` registers.
- Expected size: about 150–250 lines of RTL.

## Test plan
- **Reset, then steady stream:**
  - Stimulus: `full`=0000; stream words 0x01, 0x02, 0x03, 0x04, 0x05 with `valid_in`=1.
  - Required: pushes go to lanes 0, 1, 2, 3, 0 on consecutive cycles starting one cycle after the first accept; `push_cnt`=5; `ready_out` stays 1.
- **Skip a full lane:**
  - Stimulus: `ptr`=1, `full`=0010, word 0x1A.
  - Required: `push`=0100, `push_id`=2; `ptr` becomes 3.
- **All full stall:**
  - Stimulus: `full`=1111 while holding 0x0F for 3 cycles, then `full`=1011.
  - Required: `push`=0000 and `ready_out`=0 for 3 cycles; then `push`=0100 with `data_out`=0x0F.
- **Backpressure integrity:**
  - Stimulus: random `full` patterns with `valid_in` held high on an incrementing sequence 0–31.
  - Required: the sequence observed across all pushes is exactly 0–31, in order, with no duplicates.
- **Async reset mid-operation:**
  - Stimulus: assert `reset` between edges while holding 0x11 with `full`=1111.
  - Required: `ready_out`/`push` drop immediately; after deassertion `ptr`=0, `push_cnt`=0, and 0x11 is never pushed.
- **Counter wrap:**
  - Stimulus: 256 pushes.
  - Required: `push_cnt`=0; `ptr`=0 with `full`=0000 throughout.
